// File: rtl/inst_axi_bridge.sv
// Instruction-fetch SRAM-like to AXI read bridge: one-entry AR register,
// in-order responses tracked by an outstanding-read counter.
module inst_axi_bridge #(
    parameter int         MAX_OUTSTANDING = 2,
    parameter logic [3:0] ARID_VAL        = 4'd0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_en,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam logic       AR_IDLE = 1'b0;
    localparam logic       AR_BUSY = 1'b1;
    localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

    logic        state_q, state_d;
    logic [31:0] ar_addr_q, ar_addr_d;
    logic [2:0]  ar_size_q, ar_size_d;
    logic [1:0]  cnt_q, cnt_d;

    logic slot_free;
    logic accept;
    logic data_ok;

    // Single-ID, in-order responses: rid/rresp/rlast carry nothing we need.
    logic unused_r_fields;
    assign unused_r_fields = ^{rid, rresp, rlast};

    assign slot_free = (state_q == AR_IDLE) || arready;
    assign accept    = !reset && inst_sram_en && !inst_sram_wr && slot_free
                       && (cnt_q < MAX_CNT);
    assign rready    = !reset && (cnt_q != 2'd0);
    assign data_ok   = rvalid && rready;

    assign inst_sram_addr_ok = accept;
    assign inst_sram_data_ok = data_ok;
    assign inst_sram_rdata   = rdata;

    assign arid    = ARID_VAL;
    assign araddr  = ar_addr_q;
    assign arsize  = ar_size_q;
    assign arlen   = '0;
    assign arburst = 2'b01;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;
    assign arvalid = !reset && (state_q == AR_BUSY);

    always_comb begin
        state_d   = state_q;
        ar_addr_d = ar_addr_q;
        ar_size_d = ar_size_q;
        if (accept) begin
            state_d   = AR_BUSY;
            ar_addr_d = inst_sram_addr;
            ar_size_d = {1'b0, inst_sram_size};
        end else if ((state_q == AR_BUSY) && arready) begin
            state_d = AR_IDLE;
        end
    end

    // accept is blocked at MAX_CNT and data_ok at zero, so this never wraps.
    always_comb begin
        cnt_d = cnt_q + {1'b0, accept} - {1'b0, data_ok};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= AR_IDLE;
            ar_addr_q <= '0;
            ar_size_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ar_addr_q <= ar_addr_d;
            ar_size_q <= ar_size_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Bench for inst_axi_bridge: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_inst_axi_bridge;

    localparam int         MAX = 2;
    localparam logic [3:0] ID  = 4'd5;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_en, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: reads accepted but not completed, and the request
    // last accepted (still waiting for its AR handshake when pending=1).
    int unsigned m_outstanding;
    bit          m_pending;
    logic [31:0] m_addr;
    logic [2:0]  m_size;
    bit          e_accept, e_done;

    always #5 clk = ~clk;

    inst_axi_bridge #(.MAX_OUTSTANDING(MAX), .ARID_VAL(ID)) dut (
        .clk(clk), .reset(reset),
        .inst_sram_en(inst_sram_en), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Mid-cycle: predict every output from the model and the driven inputs.
    task automatic sample();
        bit can_take, resp_ok;
        #4;
        can_take = !m_pending || arready;
        e_accept = !reset && inst_sram_en && !inst_sram_wr && can_take && (m_outstanding < MAX);
        resp_ok  = !reset && (m_outstanding > 0);
        e_done   = rvalid && resp_ok;
        check("addr_ok", inst_sram_addr_ok, e_accept);
        check("data_ok", inst_sram_data_ok, e_done);
        check("rready",  rready, resp_ok);
        check("arvalid", arvalid, !reset && m_pending);
        check("araddr",  araddr, m_addr);
        check("arsize",  arsize, m_size);
        if (e_done) check("rdata", inst_sram_rdata, rdata);
        check("ar_const", {arid, arlen, arburst, arlock, arcache, arprot},
              {ID, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
    endtask

    task automatic advance();
        @(posedge clk);
        if (reset) begin
            m_outstanding = 0;
            m_pending     = 0;
            m_addr        = '0;
            m_size        = '0;
        end else begin
            if (e_accept) begin
                m_pending = 1;
                m_addr    = inst_sram_addr;
                m_size    = {1'b0, inst_sram_size};
            end else if (m_pending && arready) begin
                m_pending = 0;
            end
            m_outstanding = m_outstanding + (e_accept ? 1 : 0) - (e_done ? 1 : 0);
        end
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic idle_inputs();
        reset = 0; inst_sram_en = 0; inst_sram_wr = 0; inst_sram_size = 2'b10;
        inst_sram_addr = '0; arready = 1; rvalid = 0; rdata = '0;
        rid = '0; rresp = '0; rlast = 1;
    endtask

    task automatic drain(input int unsigned n);
        inst_sram_en = 0; arready = 1; rvalid = 1;
        for (int unsigned i = 0; i < n; i++) begin
            rdata = $urandom;
            cycle();
        end
        rvalid = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        @(posedge clk); #1;
        m_outstanding = 0; m_pending = 0; m_addr = '0; m_size = '0;
        cycle();
        reset = 0;
        cycle();

        // Single fetch
        inst_sram_en = 1; inst_sram_addr = 32'hbfc00000;
        sample(); check("t1_addr_ok", inst_sram_addr_ok, 1); advance();
        inst_sram_en = 0;
        sample(); check("t1_arvalid", arvalid, 1); check("t1_araddr", araddr, 32'hbfc00000);
        check("t1_arsize", arsize, 3'b010); advance();
        rvalid = 1; rdata = 32'h3c1a0000;
        sample(); check("t1_data_ok", inst_sram_data_ok, 1);
        check("t1_rdata", inst_sram_rdata, 32'h3c1a0000); advance();
        rvalid = 0;
        sample(); check("t1_idle_rready", rready, 0); advance();

        // AR backpressure with a changing fetch address
        arready = 0; inst_sram_en = 1; inst_sram_addr = 32'hbfc00004;
        cycle();
        for (int unsigned i = 0; i < 4; i++) begin
            inst_sram_addr = i[0] ? 32'hbfc00004 : 32'hbfc00010;
            sample(); check("t2_hold", araddr, 32'hbfc00004);
            check("t2_stall", inst_sram_addr_ok, 0); advance();
        end
        arready = 1; inst_sram_addr = 32'hbfc00010;
        sample(); check("t2_release", inst_sram_addr_ok, 1); advance();
        drain(3);

        // Outstanding limit
        inst_sram_en = 1;
        inst_sram_addr = 32'h1000; cycle();
        inst_sram_addr = 32'h1004; cycle();
        inst_sram_addr = 32'h1008;
        sample(); check("t3_full", inst_sram_addr_ok, 0); advance();
        rvalid = 1; rdata = 32'h11111111;
        sample(); check("t3_no_bypass", inst_sram_addr_ok, 0);
        check("t3_done", inst_sram_data_ok, 1); advance();
        rvalid = 0;
        sample(); check("t3_after", inst_sram_addr_ok, 1); advance();
        drain(3);

        // Simultaneous accept and completion at one outstanding
        inst_sram_en = 1; inst_sram_addr = 32'h2000; cycle();
        inst_sram_addr = 32'h2004; rvalid = 1; rdata = 32'h22222222;
        sample(); check("t4_aok", inst_sram_addr_ok, 1);
        check("t4_dok", inst_sram_data_ok, 1); advance();
        inst_sram_en = 0; rvalid = 0;
        sample(); check("t4_still_one", rready, 1); advance();
        drain(2);

        // Reset mid-transaction
        arready = 0; inst_sram_en = 1; inst_sram_addr = 32'h3000; cycle();
        arready = 1; inst_sram_addr = 32'h3004; cycle();
        arready = 0; inst_sram_en = 0; reset = 1;
        cycle();
        reset = 0;
        sample(); check("t5_arvalid", arvalid, 0); check("t5_rready", rready, 0); advance();
        rvalid = 1;
        sample(); check("t5_late_r", rready, 0); check("t5_late_dok", inst_sram_data_ok, 0); advance();
        rvalid = 0; arready = 1;

        // Write request is never accepted
        inst_sram_en = 1; inst_sram_wr = 1; inst_sram_addr = 32'h4000;
        sample(); check("t6_wr", inst_sram_addr_ok, 0); advance();
        inst_sram_en = 0; inst_sram_wr = 0;
        sample(); check("t6_no_ar", arvalid, 0); advance();

        // Randomized traffic
        for (int unsigned i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 99) == 0);
            inst_sram_en   = ($urandom_range(0, 3) != 0);
            inst_sram_wr   = ($urandom_range(0, 7) == 0);
            inst_sram_size = 2'($urandom_range(0, 3));
            inst_sram_addr = $urandom & 32'hfffffffc;
            arready        = ($urandom_range(0, 2) != 0);
            rvalid         = ($urandom_range(0, 2) == 0);
            rdata          = $urandom;
            rid            = 4'($urandom);
            rresp          = 2'($urandom);
            rlast          = 1'($urandom);
            cycle();
        end
        idle_inputs();
        drain(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_axi_bridge.md
INST_AXI_BRIDGE -- requirements
Module: inst_axi_bridge

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, meaning the maximum number of accepted but not yet completed read requests (range 1..3).
REQ-002 SHALL have parameter ARID_VAL, default 4'd0, meaning the ID driven on every AR transfer.
REQ-003 clk  in  1  the single clock; all logic is rising-edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 inst_sram_en  in  1  fetch request valid.
REQ-006 inst_sram_wr  in  1  write flag; always 0 from the fetch stage.
REQ-007 inst_sram_size  in  2  log2 of the byte count; 2'b10 means a word.
REQ-008 inst_sram_addr  in  32  fetch address.
REQ-009 inst_sram_addr_ok  out  1  request accepted this cycle.
REQ-010 inst_sram_data_ok  out  1  one read completes this cycle.
REQ-011 inst_sram_rdata  out  32  data of the completing read.
REQ-012 arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  out  4/32/8/3/2/2/4/3  AXI read address channel fields.
REQ-013 arvalid  out  1; arready  in  1.
REQ-014 rid  in  4; rdata  in  32; rresp  in  2; rlast  in  1; rvalid  in  1; rready  out  1.

Function
REQ-015 SHALL hold a one-entry AR register (ar_addr, ar_size) and an outstanding counter cnt (0..MAX_OUTSTANDING).
REQ-016 SHALL implement AR FSM states AR_IDLE (register empty, arvalid=0) and AR_BUSY (register full, arvalid=1).
REQ-017 SHALL compute slot_free = (state==AR_IDLE) || arready.
REQ-018 SHALL compute accept = inst_sram_en && !inst_sram_wr && slot_free && (cnt < MAX_OUTSTANDING), with no same-cycle bypass from an R completion.
REQ-019 SHALL drive inst_sram_addr_ok = accept combinationally, in the same cycle as the request.
REQ-020 On accept, SHALL latch inst_sram_addr and {1'b0, inst_sram_size} into the AR register at the next edge and enter or stay in AR_BUSY.
REQ-021 SHALL move AR_BUSY -> AR_IDLE when arready=1 and accept=0.
REQ-022 SHALL keep araddr/arsize stable while arvalid=1 && arready=0, even if inst_sram_addr changes.
REQ-023 SHALL tie arid=ARID_VAL, arlen=0, arburst=2'b01, arlock=0, arcache=0, arprot=0.
REQ-024 SHALL drive rready = (cnt != 0); rvalid while cnt==0 SHALL be left unacknowledged.
REQ-025 SHALL drive inst_sram_data_ok = rvalid && rready, with inst_sram_rdata = rdata passed through combinationally; rresp and rid are ignored.
REQ-026 SHALL update cnt as cnt + accept - data_ok; a simultaneous accept and completion leaves cnt unchanged, and cnt SHALL never wrap.
REQ-027 SHALL return responses in request order (single ID); no reordering storage is required.
REQ-028 Requests with inst_sram_wr=1 SHALL never receive addr_ok.

Reset
REQ-029 On reset=1, SHALL set state=AR_IDLE and cnt=0, and clear the AR register to 0 at the next edge.
REQ-030 During and immediately after reset, arvalid, rready, addr_ok and data_ok SHALL be 0.
REQ-031 Reset asserted mid-transaction SHALL drop all outstanding state; responses arriving afterwards SHALL be left unacknowledged because cnt=0.

Verification
REQ-032 Single fetch: en=1, addr=0xbfc00000, arready=1, rvalid 2 cycles later with rdata=0x3c1a0000 -> addr_ok in cycle 0, arvalid/araddr=0xbfc00000 in cycle 1, data_ok with rdata 0x3c1a0000, cnt back to 0.
REQ-033 AR backpressure: arready=0 for 4 cycles while inst_sram_addr toggles 0xbfc00004/0xbfc00010 -> araddr holds the accepted value 0xbfc00004, and addr_ok=0 until arready=1.
REQ-034 Outstanding limit: three back-to-back requests with R delayed -> first two accepted, third sees addr_ok=0 until the first data_ok; cnt peaks at 2.
REQ-035 Simultaneous accept and completion at cnt=1 -> cnt stays 1 and both addr_ok and data_ok pulse in the same cycle.
REQ-036 Reset with cnt=2 and arvalid=1 -> next cycle arvalid=0, cnt=0, and a later rvalid=1 sees rready=0.
REQ-037 Request with wr=1 -> addr_ok=0 and no AR issued.
